// File: rtl/subleq_pkg.sv
// -----------------------------------------------------------------------------
// subleq_pkg
// Shared definitions for the SUBLEQ core and its bench memory model:
//   - state_t    : core FSM state encoding
//   - INSTR_LEN  : words per instruction (A, B, C)
//   - DEF_DATA_W : default word width
//   - DEF_ADDR_W : default word-address width
// -----------------------------------------------------------------------------
package subleq_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 16;
   localparam int INSTR_LEN  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_A,
      ST_FETCH_B,
      ST_FETCH_C,
      ST_READ_A,
      ST_READ_B,
      ST_WRITE_B,
      ST_HALT
   } state_t;

endpackage

// File: rtl/subleq_alu.sv
// -----------------------------------------------------------------------------
// subleq_alu
// Combinational SUBLEQ arithmetic: res = vb - va (mod 2^DATA_W) and the
// branch condition leq = (res == 0) | sign(res). Overflow is not detected;
// the condition is taken from the truncated result.
// Ports:
//   va  in  DATA_W : operand read from address A
//   vb  in  DATA_W : operand read from address B
//   res out DATA_W : difference written back to B
//   leq out 1      : result is zero or negative
// -----------------------------------------------------------------------------
module subleq_alu
   import subleq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] va,
   input  logic [DATA_W-1:0] vb,
   output logic [DATA_W-1:0] res,
   output logic              leq
);

   always_comb begin
      res = vb - va;
      leq = (res == '0) | res[DATA_W-1];
   end

endmodule

// File: rtl/subleq_core.sv
// -----------------------------------------------------------------------------
// subleq_core
// Parametrised SUBLEQ processor. Fetches A, B, C at pc..pc+2, performs
// mem[B] <= mem[B] - mem[A] and branches to C when the result is <= 0.
// A taken branch with a negative C halts the core. All memory traffic uses a
// single registered req/ack port, so any memory latency is tolerated.
//
// Parameters: DATA_W (word width), ADDR_W (address width, <= DATA_W),
//             START_PC (pc loaded on start)
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : one-cycle pulse, accepted in IDLE/HALT only
//   mem_req/we/addr/wdata: registered access request, held until acked
//   mem_ack, mem_rdata   : access completes on an edge with req && ack
//   busy, halted, pc     : status
//   instr_count          : retired-instruction counter (SUBLEQ_PERF_EN only)
//
// Optional feature macro: SUBLEQ_PERF_EN adds the instr_count output.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | after reset, waiting for start
// ST_FETCH_A | reading word pc     into a_r
// ST_FETCH_B | reading word pc+1   into b_r
// ST_FETCH_C | reading word pc+2   into c_r
// ST_READ_A  | reading mem[a_r]    into va
// ST_READ_B  | reading mem[b_r], computing res/leq
// ST_WRITE_B | writing res to mem[b_r], then branch/halt
// ST_HALT    | stopped by a taken branch to negative C
// -----------------------------------------------------------------------------
module subleq_core
   import subleq_pkg::*;
#(
   parameter int          DATA_W   = DEF_DATA_W,
   parameter int          ADDR_W   = DEF_ADDR_W,
   parameter int unsigned START_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
`ifdef SUBLEQ_PERF_EN
   ,
   output logic [31:0]       instr_count
`endif
);

   localparam logic [ADDR_W-1:0] START_PC_A = ADDR_W'(START_PC);

   state_t              state;
   logic [ADDR_W-1:0]   a_r;
   logic [ADDR_W-1:0]   b_r;
   logic [ADDR_W-1:0]   c_r;
   logic                c_neg;
   logic [DATA_W-1:0]   va;
   logic                leq_r;
   logic [DATA_W-1:0]   res;
   logic                leq;
   logic [ADDR_W-1:0]   pc_next;

   // vb feeds straight from the READ_B read data; res/leq are captured on
   // that ack edge so the write data is ready when WRITE_B starts.
   subleq_alu #(.DATA_W(DATA_W)) u_alu (
      .va  (va),
      .vb  (mem_rdata),
      .res (res),
      .leq (leq)
   );

   assign pc_next = leq_r ? c_r : pc + ADDR_W'(INSTR_LEN);
   assign busy    = (state != ST_IDLE) && (state != ST_HALT);
   assign halted  = (state == ST_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= START_PC_A;
         a_r         <= '0;
         b_r         <= '0;
         c_r         <= '0;
         c_neg       <= 1'b0;
         va          <= '0;
         leq_r       <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
`ifdef SUBLEQ_PERF_EN
         instr_count <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state    <= ST_FETCH_A;
                  pc       <= START_PC_A;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= START_PC_A;
`ifdef SUBLEQ_PERF_EN
                  instr_count <= '0;
`endif
               end
            end
            ST_FETCH_A: begin
               if (mem_ack) begin
                  a_r      <= mem_rdata[ADDR_W-1:0];
                  mem_addr <= pc + ADDR_W'(1);
                  state    <= ST_FETCH_B;
               end
            end
            ST_FETCH_B: begin
               if (mem_ack) begin
                  b_r      <= mem_rdata[ADDR_W-1:0];
                  mem_addr <= pc + ADDR_W'(2);
                  state    <= ST_FETCH_C;
               end
            end
            ST_FETCH_C: begin
               if (mem_ack) begin
                  c_r      <= mem_rdata[ADDR_W-1:0];
                  c_neg    <= mem_rdata[DATA_W-1];
                  mem_addr <= a_r;
                  state    <= ST_READ_A;
               end
            end
            ST_READ_A: begin
               if (mem_ack) begin
                  va       <= mem_rdata;
                  mem_addr <= b_r;
                  state    <= ST_READ_B;
               end
            end
            ST_READ_B: begin
               if (mem_ack) begin
                  mem_wdata <= res;
                  leq_r     <= leq;
                  mem_we    <= 1'b1;
                  state     <= ST_WRITE_B;
               end
            end
            ST_WRITE_B: begin
               if (mem_ack) begin
                  mem_we <= 1'b0;
`ifdef SUBLEQ_PERF_EN
                  instr_count <= instr_count + 32'd1;
`endif
                  if (leq_r && c_neg) begin
                     mem_req <= 1'b0;
                     state   <= ST_HALT;
                  end else begin
                     pc       <= pc_next;
                     mem_addr <= pc_next;
                     state    <= ST_FETCH_A;
                  end
               end
            end
            default: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subleq_core.sv
// -----------------------------------------------------------------------------
// tb_subleq_core
// Bench for subleq_core. A wide instance (64-bit data, 16-bit address) runs
// directed and random-stall programs against a behavioural SUBLEQ interpreter;
// a narrow instance (8-bit data, 4-bit address, START_PC=14) covers pc and
// arithmetic wrap. All memory modelling happens in tick(), one call per cycle,
// sampling 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_subleq_core;
   import subleq_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_ADDR_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // wide instance
   logic          rst_n, start, mem_req, mem_we, mem_ack, busy, halted;
   logic [AW-1:0] mem_addr, pc;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef SUBLEQ_PERF_EN
   logic [31:0]   instr_count;
`endif

   subleq_core #(.DATA_W(DW), .ADDR_W(AW), .START_PC(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .halted    (halted),
      .pc        (pc)
`ifdef SUBLEQ_PERF_EN
      ,
      .instr_count (instr_count)
`endif
   );

   // narrow instance, zero-wait memory
   logic       rst2_n, start2, req2, we2, busy2, halted2;
   logic [3:0] addr2, pc2;
   logic [7:0] wdata2, rdata2;
`ifdef SUBLEQ_PERF_EN
   logic [31:0] instr_count2;
`endif

   subleq_core #(.DATA_W(8), .ADDR_W(4), .START_PC(14)) dut2 (
      .clk       (clk),
      .rst_n     (rst2_n),
      .start     (start2),
      .mem_req   (req2),
      .mem_we    (we2),
      .mem_addr  (addr2),
      .mem_wdata (wdata2),
      .mem_ack   (1'b1),
      .mem_rdata (rdata2),
      .busy      (busy2),
      .halted    (halted2),
      .pc        (pc2)
`ifdef SUBLEQ_PERF_EN
      ,
      .instr_count (instr_count2)
`endif
   );

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [7:0]    mem2    [0:15];

   int            log_cyc[$];
   logic [AW-1:0] log_addr[$];
   logic          log_we[$];
   logic [DW-1:0] log_data[$];
   logic [3:0]    log2[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // memory-model state
   int            max_stall = 0;
   int            wait_left = 0;
   bit            need_pick = 1'b1;
   bit            resp_en   = 1'b1;
   logic          force_ack = 1'b0;
   bit            pend = 1'b0, pend2 = 1'b0;
   logic [AW-1:0] p_addr;
   logic          p_we;
   logic [DW-1:0] p_data;
   logic [3:0]    p2_addr;
   logic          p2_we;
   logic [7:0]    p2_data;
   bit            prev_stall = 1'b0;
   logic [AW-1:0] s_addr;
   logic          s_we;
   logic [DW-1:0] s_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle of the memory models. Accesses granted in the previous
   // cycle are committed here, unless reset was asserted before the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pend && rst_n) begin
         if (p_we) mem[p_addr] = p_data;
         log_cyc.push_back(cyc);
         log_addr.push_back(p_addr);
         log_we.push_back(p_we);
         log_data.push_back(p_data);
         need_pick = 1'b1;
      end
      pend = 1'b0;
      if (pend2 && rst2_n) begin
         if (p2_we) mem2[p2_addr] = p2_data;
         log2.push_back(p2_addr);
      end
      pend2 = 1'b0;
      if (!rst_n) need_pick = 1'b1;

      if (prev_stall && rst_n) begin
         check("hold_req", {63'd0, mem_req}, 64'd1);
         check("hold_addr", 64'(mem_addr), 64'(s_addr));
         check("hold_we", {63'd0, mem_we}, {63'd0, s_we});
         if (s_we) check("hold_wdata", mem_wdata, s_wdata);
      end

      if (!resp_en) begin
         mem_ack = force_ack;
      end else if (mem_req) begin
         if (need_pick) begin
            wait_left = $urandom_range(max_stall, 0);
            need_pick = 1'b0;
         end
         if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
         end else begin
            mem_ack = 1'b0;
            wait_left--;
         end
      end else begin
         mem_ack = 1'b0;
      end

      if (rst_n && mem_req && mem_ack) begin
         pend   = 1'b1;
         p_addr = mem_addr;
         p_we   = mem_we;
         p_data = mem_we ? mem_wdata : mem_rdata;
      end
      prev_stall = rst_n && mem_req && !mem_ack;
      s_addr  = mem_addr;
      s_we    = mem_we;
      s_wdata = mem_wdata;

      rdata2 = mem2[addr2];
      if (rst2_n && req2) begin
         pend2   = 1'b1;
         p2_addr = addr2;
         p2_we   = we2;
         p2_data = we2 ? wdata2 : rdata2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_req", {63'd0, mem_req}, 64'd1);
      check("start_addr", 64'(mem_addr), 64'd0);
   endtask

   task automatic wait_halt(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         tick();
         if (halted) break;
      end
      if (k == budget) check("halt_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_log(input int n, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (log_addr.size() >= n) break;
         tick();
      end
      if (k == budget) check("log_timeout", 64'd0, 64'd1);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
   endtask

   task automatic load_branch_halt();
      clear_mem();
      mem[0] = 3; mem[1] = 4; mem[2] = 6;
      mem[3] = 7; mem[4] = 7;
      mem[6] = 9; mem[7] = 9; mem[8] = '1;
      mem[9] = 123;
   endtask

   // Plain SUBLEQ interpreter over ref_mem, starting at address 0.
   task automatic run_ref(output logic [AW-1:0] fpc, output int ninstr);
      logic [AW-1:0]        p, p1, p2, a, b;
      logic signed [DW-1:0] r, c;
      p = '0;
      ninstr = 0;
      for (int k = 0; k < 1000; k++) begin
         p1 = p + 1;
         p2 = p + 2;
         a  = ref_mem[p][AW-1:0];
         b  = ref_mem[p1][AW-1:0];
         c  = ref_mem[p2];
         r  = $signed(ref_mem[b]) - $signed(ref_mem[a]);
         ref_mem[b] = r;
         ninstr++;
         if (r <= 0) begin
            if (c < 0) break;
            p = c[AW-1:0];
         end else begin
            p = p + 3;
         end
      end
      fpc = p;
   endtask

   // clear Z; n_add x (Z -= X; Y -= Z; Z = 0); halt via Z,Z,-1
   task automatic build_add_prog(input int n_add);
      int a;
      int x, y;
      clear_mem();
      for (int i = 100; i < 112; i++) mem[i] = {$urandom, $urandom};
      mem[99] = {$urandom, $urandom};
      a = 0;
      mem[a] = 99; mem[a+1] = 99; mem[a+2] = 64'(a + 3); a += 3;
      for (int k = 0; k < n_add; k++) begin
         x = 100 + $urandom_range(11, 0);
         y = 100 + $urandom_range(11, 0);
         mem[a] = 64'(x);  mem[a+1] = 99;      mem[a+2] = 64'(a + 3); a += 3;
         mem[a] = 99;      mem[a+1] = 64'(y);  mem[a+2] = 64'(a + 3); a += 3;
         mem[a] = 99;      mem[a+1] = 99;      mem[a+2] = 64'(a + 3); a += 3;
      end
      mem[a] = 99; mem[a+1] = 99; mem[a+2] = '1;
   endtask

   initial begin
      int            base;
      int            nref;
      int            nw;
      logic [AW-1:0] rpc;

      rst_n = 1'b0; rst2_n = 1'b0;
      start = 1'b0; start2 = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0; rdata2 = '0;
      clear_mem();
      for (int i = 0; i < 16; i++) mem2[i] = '0;
      tick();
      tick();

      // reset state
      check("rst_req", {63'd0, mem_req}, 64'd0);
      check("rst_we", {63'd0, mem_we}, 64'd0);
      check("rst_addr", 64'(mem_addr), 64'd0);
      check("rst_wdata", mem_wdata, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_halted", {63'd0, halted}, 64'd0);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst2_pc", 64'(pc2), 64'd14);
      rst_n = 1'b1;
      tick();

      // not-taken instruction, zero wait
      clear_mem();
      mem[0] = 3; mem[1] = 4; mem[2] = 6; mem[3] = 5; mem[4] = 7;
      max_stall = 0;
      base = log_addr.size();
      do_start();
      check("t1_busy", {63'd0, busy}, 64'd1);
      wait_log(base + 7, 50);
      check("t1_seq0", 64'(log_addr[base+0]), 64'd0);
      check("t1_seq1", 64'(log_addr[base+1]), 64'd1);
      check("t1_seq2", 64'(log_addr[base+2]), 64'd2);
      check("t1_seq3", 64'(log_addr[base+3]), 64'd3);
      check("t1_seq4", 64'(log_addr[base+4]), 64'd4);
      check("t1_wr_addr", 64'(log_addr[base+5]), 64'd4);
      check("t1_wr_we", {63'd0, log_we[base+5]}, 64'd1);
      check("t1_wr_data", log_data[base+5], 64'd2);
      check("t1_next_fetch", 64'(log_addr[base+6]), 64'd3);
      check("t1_cycles", 64'(log_cyc[base+6] - log_cyc[base+0]), 64'd6);
      check("t1_pc", 64'(pc), 64'd3);
      do_reset();

      // taken branch, then A==B with negative C halts; start while busy ignored
      load_branch_halt();
      base = log_addr.size();
      do_start();
      repeat (8) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_pc", 64'(pc), 64'd6);
      check("busy_start_busy", {63'd0, busy}, 64'd1);
      wait_halt(100);
      check("t2_halted", {63'd0, halted}, 64'd1);
      check("t2_busy", {63'd0, busy}, 64'd0);
      check("t2_pc", 64'(pc), 64'd6);
      check("t2_req", {63'd0, mem_req}, 64'd0);
      check("t2_mem4", mem[4], 64'd0);
      check("t2_mem9", mem[9], 64'd0);
      check("t2_accesses", 64'(log_addr.size() - base), 64'd12);
      check("t2_halt_timing", 64'(log_cyc[log_cyc.size()-1]), 64'(cyc));
      repeat (3) tick();
      check("t2_stay_halted", {63'd0, halted}, 64'd1);

      // reset during READ_B
      do_reset();
      load_branch_halt();
      base = log_addr.size();
      do_start();
      wait_log(base + 4, 50);
      check("rb_req", {63'd0, mem_req}, 64'd1);
      check("rb_addr", 64'(mem_addr), 64'd4);
      check("rb_we", {63'd0, mem_we}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rb_async_req", {63'd0, mem_req}, 64'd0);
      check("rb_async_busy", {63'd0, busy}, 64'd0);
      resp_en   = 1'b0;
      force_ack = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("late_ack_req", {63'd0, mem_req}, 64'd0);
      check("late_ack_busy", {63'd0, busy}, 64'd0);
      check("late_ack_pc", 64'(pc), 64'd0);
      check("late_ack_mem4", mem[4], 64'd7);
      force_ack = 1'b0;
      resp_en   = 1'b1;
      tick();
      do_start();
      wait_halt(100);
      check("restart_mem4", mem[4], 64'd0);
      check("restart_pc", 64'(pc), 64'd6);
      check("restart_halted", {63'd0, halted}, 64'd1);

      // 20-instruction clear-and-add program with random stalls
      do_reset();
      build_add_prog(6);
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
      run_ref(rpc, nref);
      max_stall = 5;
      base = log_addr.size();
      do_start();
      wait_halt(3000);
      check("rand_halted", {63'd0, halted}, 64'd1);
      check("rand_pc", 64'(pc), 64'(rpc));
      check("rand_ref_len", 64'(nref), 64'd20);
      nw = 0;
      for (int i = base; i < log_we.size(); i++) if (log_we[i]) nw++;
      check("rand_writes", 64'(nw), 64'(nref));
      for (int i = 0; i < 128; i++) check("rand_mem", mem[i], ref_mem[i]);
`ifdef SUBLEQ_PERF_EN
      check("rand_instr_count", 64'(instr_count), 64'(nref));
`endif
      max_stall = 0;

`ifdef SUBLEQ_PERF_EN
      do_reset();
      build_add_prog(1);
      do_start();
      wait_halt(200);
      check("perf_count5", 64'(instr_count), 64'd5);
      do_start();
      check("perf_clear", 64'(instr_count), 64'd0);
      do_reset();
`endif

      // narrow instance: pc wraps 14,15,0 -> 1; -128 - 1 = 127, not taken
      mem2[14] = 4'd2; mem2[15] = 4'd3; mem2[0] = 8'd5;
      mem2[2]  = 8'd1; mem2[3]  = 8'h80;
      rst2_n = 1'b1;
      tick();
      check("n_idle_pc", 64'(pc2), 64'd14);
      check("n_idle_req", {63'd0, req2}, 64'd0);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (log2.size() >= 7) break;
         tick();
      end
      if (log2.size() < 7) begin
         check("n_timeout", 64'd0, 64'd1);
      end else begin
         check("n_fetch0", 64'(log2[0]), 64'd14);
         check("n_fetch1", 64'(log2[1]), 64'd15);
         check("n_fetch2", 64'(log2[2]), 64'd0);
         check("n_read_a", 64'(log2[3]), 64'd2);
         check("n_read_b", 64'(log2[4]), 64'd3);
         check("n_write_b", 64'(log2[5]), 64'd3);
         check("n_res", 64'(mem2[3]), 64'h7f);
         check("n_next_fetch", 64'(log2[6]), 64'd1);
         check("n_pc", 64'(pc2), 64'd1);
      end
      rst2_n = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
